si57x_freq_req_sequencer: RTL and testbench

- Upstream stage of si57x_interface. Accepts Si57x frequency-change requests (RFREQ/N1/HS) from host logic over a valid/ready handshake.
- Validates each request against Si57x divider rules.
- Drives the interface's ext_wr/ext_rfreq/ext_n1/ext_hs inputs with a one-cycle write strobe.
- Enforces a hold-off so that a new write never lands while the previous I2C reprogramming sequence is still in flight.

---
 rtl/si57x_pkg.sv | 32 +++
 rtl/si57x_freq_req_sequencer.sv | 165 ++++++++++++++++
 tb/tb_si57x_freq_req_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/si57x_pkg.sv
// Shared Si57x definitions: field widths, legal divider codes and power-up defaults.
// si57x_interface uses the same init constants, so both blocks start from one frequency.
package si57x_pkg;

  localparam int unsigned C_RFREQ_W = 38;
  localparam int unsigned C_N1_W    = 7;
  localparam int unsigned C_HS_W    = 3;

  // Bit i set means HS_DIV code i is legal: codes 0,1,2,3,5,7 (dividers 4,5,6,7,9,11).
  localparam logic [7:0] C_HS_LEGAL_SET = 8'b1010_1111;

  localparam logic [C_RFREQ_W-1:0] C_INIT_RFREQ = 38'h03017a66ad;
  localparam logic [C_N1_W-1:0]    C_INIT_N1    = 7'b0000011;
  localparam logic [C_HS_W-1:0]    C_INIT_HS    = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_HOLDOFF = 2'd3
  } seq_state_e;

  function automatic logic f_hs_legal(input logic [C_HS_W-1:0] code);
    return C_HS_LEGAL_SET[code];
  endfunction

  // N1 divider is code+1 and must be 1 or even, so code is 0 or odd.
  function automatic logic f_n1_legal(input logic [C_N1_W-1:0] code);
    return (code == '0) || code[0];
  endfunction

endpackage

// File: rtl/si57x_freq_req_sequencer.sv
// Accepts Si57x frequency requests, validates divider codes, issues one write strobe
// to si57x_interface and then blocks new requests while the I2C sequence completes.
module si57x_freq_req_sequencer
  import si57x_pkg::*;
#(
  parameter int unsigned           g_HOLDOFF_CYCLES   = 100000,
  parameter logic [C_RFREQ_W-1:0]  g_INIT_RFREQ_VALUE = C_INIT_RFREQ,
  parameter logic [C_N1_W-1:0]     g_INIT_N1_VALUE    = C_INIT_N1,
  parameter logic [C_HS_W-1:0]     g_INIT_HS_VALUE    = C_INIT_HS
) (
  input  logic                  clk_sys_i,
  input  logic                  rst_n_i,
  // Request handshake: a request transfers on a rising clk_sys_i edge where
  // req_valid_i and req_ready_o are both high; while ready is low the host holds
  // the request unchanged, and valid may drop at any time before transfer.
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [C_RFREQ_W-1:0]  req_rfreq_i,
  input  logic [C_N1_W-1:0]     req_n1_i,
  input  logic [C_HS_W-1:0]     req_hs_i,
  input  logic                  clr_err_i,
  output logic                  ext_wr_o,
  output logic [C_RFREQ_W-1:0]  ext_rfreq_value_o,
  output logic [C_N1_W-1:0]     ext_n1_value_o,
  output logic [C_HS_W-1:0]     ext_hs_value_o,
  output logic                  busy_o,
  output logic                  err_hs_o,
  output logic                  err_n1_o,
  output logic                  err_rfreq_o,
  output logic [7:0]            reject_cnt_o
);

  localparam int unsigned CNT_W = (g_HOLDOFF_CYCLES > 1) ? $clog2(g_HOLDOFF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(g_HOLDOFF_CYCLES - 1);

  seq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [C_RFREQ_W-1:0]   stage_rfreq_q, stage_rfreq_d;
  logic [C_N1_W-1:0]      stage_n1_q, stage_n1_d;
  logic [C_HS_W-1:0]      stage_hs_q, stage_hs_d;
  logic [C_RFREQ_W-1:0]   ext_rfreq_q, ext_rfreq_d;
  logic [C_N1_W-1:0]      ext_n1_q, ext_n1_d;
  logic [C_HS_W-1:0]      ext_hs_q, ext_hs_d;
  logic                   wr_q, wr_d;
  logic                   err_hs_q, err_hs_d;
  logic                   err_n1_q, err_n1_d;
  logic                   err_rfreq_q, err_rfreq_d;
  logic [7:0]             rej_cnt_q, rej_cnt_d;

  logic bad_hs, bad_n1, bad_rfreq;

  assign bad_hs    = !f_hs_legal(stage_hs_q);
  assign bad_n1    = !f_n1_legal(stage_n1_q);
  assign bad_rfreq = (stage_rfreq_q == '0);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stage_rfreq_d = stage_rfreq_q;
    stage_n1_d    = stage_n1_q;
    stage_hs_d    = stage_hs_q;
    ext_rfreq_d   = ext_rfreq_q;
    ext_n1_d      = ext_n1_q;
    ext_hs_d      = ext_hs_q;
    wr_d          = 1'b0;
    err_hs_d      = err_hs_q;
    err_n1_d      = err_n1_q;
    err_rfreq_d   = err_rfreq_q;
    rej_cnt_d     = rej_cnt_q;

    // Clear first so that a rejection in the same cycle lands on a clean slate.
    if (clr_err_i) begin
      err_hs_d    = 1'b0;
      err_n1_d    = 1'b0;
      err_rfreq_d = 1'b0;
      rej_cnt_d   = '0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          stage_rfreq_d = req_rfreq_i;
          stage_n1_d    = req_n1_i;
          stage_hs_d    = req_hs_i;
          state_d       = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (bad_hs || bad_n1 || bad_rfreq) begin
          err_hs_d    = err_hs_d    | bad_hs;
          err_n1_d    = err_n1_d    | bad_n1;
          err_rfreq_d = err_rfreq_d | bad_rfreq;
          if (rej_cnt_d != 8'hFF) rej_cnt_d = rej_cnt_d + 8'd1;
          state_d = ST_IDLE;
        end else begin
          // Values and strobe are registered together so they appear in the ISSUE cycle.
          ext_rfreq_d = stage_rfreq_q;
          ext_n1_d    = stage_n1_q;
          ext_hs_d    = stage_hs_q;
          wr_d        = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = (g_HOLDOFF_CYCLES <= 1) ? ST_IDLE : ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        // Leaving as the count reaches zero makes ready return g_HOLDOFF_CYCLES
        // cycles after the strobe cycle.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      stage_rfreq_q <= '0;
      stage_n1_q    <= '0;
      stage_hs_q    <= '0;
      ext_rfreq_q   <= g_INIT_RFREQ_VALUE;
      ext_n1_q      <= g_INIT_N1_VALUE;
      ext_hs_q      <= g_INIT_HS_VALUE;
      wr_q          <= 1'b0;
      err_hs_q      <= 1'b0;
      err_n1_q      <= 1'b0;
      err_rfreq_q   <= 1'b0;
      rej_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stage_rfreq_q <= stage_rfreq_d;
      stage_n1_q    <= stage_n1_d;
      stage_hs_q    <= stage_hs_d;
      ext_rfreq_q   <= ext_rfreq_d;
      ext_n1_q      <= ext_n1_d;
      ext_hs_q      <= ext_hs_d;
      wr_q          <= wr_d;
      err_hs_q      <= err_hs_d;
      err_n1_q      <= err_n1_d;
      err_rfreq_q   <= err_rfreq_d;
      rej_cnt_q     <= rej_cnt_d;
    end
  end

  assign req_ready_o       = (state_q == ST_IDLE);
  assign busy_o            = (state_q != ST_IDLE);
  assign ext_wr_o          = wr_q;
  assign ext_rfreq_value_o = ext_rfreq_q;
  assign ext_n1_value_o    = ext_n1_q;
  assign ext_hs_value_o    = ext_hs_q;
  assign err_hs_o          = err_hs_q;
  assign err_n1_o          = err_n1_q;
  assign err_rfreq_o       = err_rfreq_q;
  assign reject_cnt_o      = rej_cnt_q;

endmodule

// File: tb/tb_si57x_freq_req_sequencer.sv
// Directed bench for si57x_freq_req_sequencer with a 16-cycle hold-off.
module tb_si57x_freq_req_sequencer;

  localparam int unsigned HOLD = 16;

  logic        clk_sys_i;
  logic        rst_n_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [37:0] req_rfreq_i;
  logic [6:0]  req_n1_i;
  logic [2:0]  req_hs_i;
  logic        clr_err_i;
  logic        ext_wr_o;
  logic [37:0] ext_rfreq_value_o;
  logic [6:0]  ext_n1_value_o;
  logic [2:0]  ext_hs_value_o;
  logic        busy_o;
  logic        err_hs_o;
  logic        err_n1_o;
  logic        err_rfreq_o;
  logic [7:0]  reject_cnt_o;

  int total = 0;
  int bad   = 0;

  logic [37:0] exp_rfreq;
  logic [6:0]  exp_n1;
  logic [2:0]  exp_hs;

  si57x_freq_req_sequencer #(
    .g_HOLDOFF_CYCLES   (HOLD),
    .g_INIT_RFREQ_VALUE (38'h03017a66ad),
    .g_INIT_N1_VALUE    (7'b0000011),
    .g_INIT_HS_VALUE    (3'b111)
  ) dut (
    .clk_sys_i         (clk_sys_i),
    .rst_n_i           (rst_n_i),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_rfreq_i       (req_rfreq_i),
    .req_n1_i          (req_n1_i),
    .req_hs_i          (req_hs_i),
    .clr_err_i         (clr_err_i),
    .ext_wr_o          (ext_wr_o),
    .ext_rfreq_value_o (ext_rfreq_value_o),
    .ext_n1_value_o    (ext_n1_value_o),
    .ext_hs_value_o    (ext_hs_value_o),
    .busy_o            (busy_o),
    .err_hs_o          (err_hs_o),
    .err_n1_o          (err_n1_o),
    .err_rfreq_o       (err_rfreq_o),
    .reject_cnt_o      (reject_cnt_o)
  );

  // Clock and watchdog
  initial clk_sys_i = 1'b0;
  always #5 clk_sys_i = ~clk_sys_i;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk_sys_i);
    #1;
  endtask

  task automatic chk_ext(input string tag);
    chk({tag, "_rfreq"}, 64'(ext_rfreq_value_o), 64'(exp_rfreq));
    chk({tag, "_n1"},    64'(ext_n1_value_o),    64'(exp_n1));
    chk({tag, "_hs"},    64'(ext_hs_value_o),    64'(exp_hs));
  endtask

  // Legal request: strobe two cycles after acceptance, ready back HOLD cycles after strobe.
  task automatic send_legal(input string tag, input logic [37:0] rf, input logic [6:0] n1,
                            input logic [2:0] hs);
    int n;
    int extra_wr;
    chk({tag, "_ready_pre"}, 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1; req_rfreq_i = rf; req_n1_i = n1; req_hs_i = hs;
    tick();
    req_valid_i = 1'b0;
    chk({tag, "_ready_check"}, 64'(req_ready_o), 64'd0);
    chk({tag, "_wr_check"},    64'(ext_wr_o),    64'd0);
    chk({tag, "_busy_check"},  64'(busy_o),      64'd1);
    tick();
    chk({tag, "_wr_issue"}, 64'(ext_wr_o), 64'd1);
    exp_rfreq = rf; exp_n1 = n1; exp_hs = hs;
    chk_ext({tag, "_issue"});
    n = 0;
    extra_wr = 0;
    while (n < 40) begin
      tick();
      n++;
      if (ext_wr_o) extra_wr++;
      if (req_ready_o) break;
    end
    chk({tag, "_ready_gap"}, 64'(n), 64'(HOLD));
    chk({tag, "_extra_wr"},  64'(extra_wr), 64'd0);
    chk_ext({tag, "_held"});
  endtask

  // Illegal request: no strobe, ready back one cycle after CHECK, sticky flags and count.
  task automatic send_reject(input string tag, input logic [37:0] rf, input logic [6:0] n1,
                             input logic [2:0] hs, input logic [2:0] exp_flags,
                             input logic [7:0] exp_cnt);
    chk({tag, "_ready_pre"}, 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1; req_rfreq_i = rf; req_n1_i = n1; req_hs_i = hs;
    tick();
    req_valid_i = 1'b0;
    chk({tag, "_ready_check"}, 64'(req_ready_o), 64'd0);
    chk({tag, "_wr_check"},    64'(ext_wr_o),    64'd0);
    tick();
    chk({tag, "_ready_after"}, 64'(req_ready_o), 64'd1);
    chk({tag, "_wr_after"},    64'(ext_wr_o),    64'd0);
    chk({tag, "_flags"}, 64'({err_rfreq_o, err_n1_o, err_hs_o}), 64'(exp_flags));
    chk({tag, "_cnt"},   64'(reject_cnt_o), 64'(exp_cnt));
    chk_ext({tag, "_ext"});
  endtask

  initial begin
    int c;
    int accepts;
    int wr_cnt;
    int wr_at [2];
    int sat_wr;

    rst_n_i = 1'b0; req_valid_i = 1'b0; clr_err_i = 1'b0;
    req_rfreq_i = '0; req_n1_i = '0; req_hs_i = '0;
    exp_rfreq = 38'h03017a66ad; exp_n1 = 7'd3; exp_hs = 3'd7;
    repeat (3) tick();
    rst_n_i = 1'b1;
    tick();

    // Reset state
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    chk("rst_wr",    64'(ext_wr_o),    64'd0);
    chk("rst_busy",  64'(busy_o),      64'd0);
    chk("rst_flags", 64'({err_rfreq_o, err_n1_o, err_hs_o}), 64'd0);
    chk("rst_cnt",   64'(reject_cnt_o), 64'd0);
    chk_ext("rst");

    // Legal requests, including boundary codes n1=0, hs=5, rfreq=1
    send_legal("leg1", 38'h02BC011EB8, 7'd7, 3'd0);
    send_legal("leg2", 38'h0000000001, 7'd0, 3'd5);

    // Rejections accumulate sticky flags {rfreq,n1,hs}
    send_reject("rej_hs",    38'h02BC011EB8, 7'd7, 3'd4, 3'b001, 8'd1);
    send_reject("rej_n1",    38'h02BC011EB8, 7'd2, 3'd0, 3'b011, 8'd2);
    send_reject("rej_rfreq", 38'h0000000000, 7'd7, 3'd0, 3'b111, 8'd3);

    // Back-to-back: valid held high, second request waits out the hold-off
    req_valid_i = 1'b1; req_rfreq_i = 38'h0123456789; req_n1_i = 7'd1; req_hs_i = 3'd2;
    accepts = 0; wr_cnt = 0; wr_at[0] = -1; wr_at[1] = -1;
    for (int i = 0; i < 60; i++) begin
      if (req_valid_i && req_ready_o) accepts++;
      tick();
      if (accepts == 1) begin
        req_rfreq_i = 38'h3FFFFFFFFF; req_n1_i = 7'd127; req_hs_i = 3'd3;
      end
      if (accepts == 2) req_valid_i = 1'b0;
      if (ext_wr_o) begin
        if (wr_cnt < 2) wr_at[wr_cnt] = i;
        wr_cnt++;
        if (wr_cnt == 2) begin
          exp_rfreq = 38'h3FFFFFFFFF; exp_n1 = 7'd127; exp_hs = 3'd3;
          chk_ext("b2b_second");
        end
      end
    end
    req_valid_i = 1'b0;
    chk("b2b_pulses",  64'(wr_cnt), 64'd2);
    chk("b2b_spacing", 64'(wr_at[1] - wr_at[0]), 64'd18);
    chk("b2b_idle",    64'(req_ready_o), 64'd1);

    // Saturation of the reject counter
    sat_wr = 0;
    req_rfreq_i = 38'h1; req_n1_i = 7'd1; req_hs_i = 3'd6;
    for (int i = 0; i < 300; i++) begin
      req_valid_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
      if (ext_wr_o) sat_wr++;
      tick();
      if (ext_wr_o) sat_wr++;
    end
    chk("sat_cnt",   64'(reject_cnt_o), 64'd255);
    chk("sat_wr",    64'(sat_wr), 64'd0);
    chk("sat_flags", 64'({err_rfreq_o, err_n1_o, err_hs_o}), 64'b111);
    chk_ext("sat");

    // clr_err_i coinciding with a new N1 rejection in CHECK
    req_valid_i = 1'b1; req_rfreq_i = 38'h5; req_n1_i = 7'd4; req_hs_i = 3'd1;
    tick();
    req_valid_i = 1'b0;
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    chk("clr_race_flags", 64'({err_rfreq_o, err_n1_o, err_hs_o}), 64'b010);
    chk("clr_race_cnt",   64'(reject_cnt_o), 64'd1);

    // Plain clear
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    chk("clr_flags", 64'({err_rfreq_o, err_n1_o, err_hs_o}), 64'd0);
    chk("clr_cnt",   64'(reject_cnt_o), 64'd0);

    // Reset asserted during HOLDOFF
    req_valid_i = 1'b1; req_rfreq_i = 38'h0A0A0A0A0A; req_n1_i = 7'd5; req_hs_i = 3'd1;
    tick();
    req_valid_i = 1'b0;
    tick();
    chk("hr_wr_issue", 64'(ext_wr_o), 64'd1);
    repeat (4) tick();
    chk("hr_busy_pre", 64'(busy_o), 64'd1);
    rst_n_i = 1'b0;
    #2;
    exp_rfreq = 38'h03017a66ad; exp_n1 = 7'd3; exp_hs = 3'd7;
    chk("hr_wr",    64'(ext_wr_o), 64'd0);
    chk("hr_busy",  64'(busy_o),   64'd0);
    chk_ext("hr");
    tick();
    rst_n_i = 1'b1;
    tick();
    chk("hr_ready", 64'(req_ready_o), 64'd1);
    chk("hr_busy_after", 64'(busy_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
